// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the uart_bridge CPU front-end: register map,
// status bit positions, uart status bits and poll FSM states.
package uart_bridge_pkg;

    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_STAT  = 2'd1;
    localparam logic [1:0] REG_CTRL  = 2'd2;
    localparam logic [1:0] REG_RXCNT = 2'd3;

    localparam int ST_TXFULL   = 7;
    localparam int ST_RXNEMPTY = 6;
    localparam int ST_RXOVR    = 5;
    localparam int ST_TXEMPTY  = 4;
    localparam int ST_TXOVF    = 3;

    localparam int U_TXBUSY = 7;
    localparam int U_RXOK   = 6;

    typedef enum logic [1:0] {
        POLL  = 2'd0,
        STAT  = 2'd1,
        RXACK = 2'd2,
        TXWR  = 2'd3
    } poll_state_t;

endpackage

// File: rtl/uart_bridge_sync_fifo.sv
// Single-clock FIFO with combinational head output and an AW+1 bit occupancy
// count so that a completely full FIFO (count == DEPTH) is representable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == DEPTH[AW:0]);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/uart_bridge.sv
// Buffered 6502-side front-end for the 8-bit uart: TX/RX FIFOs, status/control/IRQ
// registers and a poll FSM that shuttles bytes between the FIFOs and the uart bus port.
module uart_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cpu_addr,
    input  logic       cpu_we,
    input  logic       cpu_re,
    input  logic [7:0] cpu_dbw,
    output logic [7:0] cpu_dbr,
    output logic       irq,
    output logic       u_addr,
    output logic       u_we,
    output logic [7:0] u_dbw,
    input  logic [7:0] u_dbr
);

    poll_state_t state_reg;
    logic        rx_ie_reg;
    logic        tx_ie_reg;
    logic        rx_ovr_reg;
    logic        tx_ovf_reg;

    logic        cpu_rd;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  tx_head, rx_head;
    logic [AW:0] tx_count, rx_count;
    logic        go_rx, go_tx, rx_ovr_set, tx_ovf_set, ctrl_wr;
    logic [7:0]  status;

    // A simultaneous write and read is treated as a write only.
    assign cpu_rd  = cpu_re & ~cpu_we;
    assign ctrl_wr = cpu_we && (cpu_addr == REG_CTRL);

    assign tx_push    = cpu_we && (cpu_addr == REG_DATA);
    assign tx_ovf_set = tx_push && tx_full;
    assign rx_pop     = cpu_rd && (cpu_addr == REG_DATA);

    // STAT decisions: a waiting rx byte wins; if it cannot be taken, TX may still go.
    assign go_rx      = (state_reg == STAT) && u_dbr[U_RXOK] && !rx_full;
    assign rx_ovr_set = (state_reg == STAT) && u_dbr[U_RXOK] && rx_full;
    assign go_tx      = (state_reg == STAT) && !go_rx && !u_dbr[U_TXBUSY] && !tx_empty;
    assign tx_pop     = go_tx;
    assign rx_push    = (state_reg == RXACK);

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) tx_q (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (cpu_dbw),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) rx_q (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (u_dbr),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_comb begin
        status              = 8'h00;
        status[ST_TXFULL]   = tx_full;
        status[ST_RXNEMPTY] = ~rx_empty;
        status[ST_RXOVR]    = rx_ovr_reg;
        status[ST_TXEMPTY]  = tx_empty;
        status[ST_TXOVF]    = tx_ovf_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_dbr <= 8'h00;
        end else if (cpu_rd) begin
            case (cpu_addr)
                REG_DATA:  cpu_dbr <= rx_empty ? 8'h00 : rx_head;
                REG_STAT:  cpu_dbr <= status;
                REG_CTRL:  cpu_dbr <= {6'b0, tx_ie_reg, rx_ie_reg};
                REG_RXCNT: cpu_dbr <= 8'(rx_count);
            endcase
        end
    end

    // A flag set in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ie_reg  <= 1'b0;
            tx_ie_reg  <= 1'b0;
            rx_ovr_reg <= 1'b0;
            tx_ovf_reg <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                rx_ie_reg <= cpu_dbw[0];
                tx_ie_reg <= cpu_dbw[1];
            end
            if (ctrl_wr && cpu_dbw[7]) begin
                rx_ovr_reg <= 1'b0;
                tx_ovf_reg <= 1'b0;
            end
            if (rx_ovr_set)
                rx_ovr_reg <= 1'b1;
            if (tx_ovf_set)
                tx_ovf_reg <= 1'b1;
            irq <= (rx_ie_reg & ~rx_empty) | (tx_ie_reg & tx_empty);
        end
    end

    // u_* are loaded on entry to a state so they are valid during that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= POLL;
            u_we      <= 1'b0;
            u_addr    <= 1'b0;
            u_dbw     <= 8'h00;
        end else begin
            case (state_reg)
                POLL: begin
                    // Right after reset u_addr is 0, so spend one extra POLL
                    // cycle addressing status before trusting STAT.
                    u_we <= 1'b0;
                    if (u_addr) begin
                        state_reg <= STAT;
                        u_addr    <= 1'b0;
                    end else begin
                        u_addr <= 1'b1;
                    end
                end
                STAT: begin
                    if (go_rx) begin
                        state_reg <= RXACK;
                        u_we      <= 1'b1;
                        u_addr    <= 1'b1;
                    end else if (go_tx) begin
                        state_reg <= TXWR;
                        u_we      <= 1'b1;
                        u_addr    <= 1'b0;
                        u_dbw     <= tx_head;
                    end else begin
                        state_reg <= POLL;
                        u_we      <= 1'b0;
                        u_addr    <= 1'b1;
                    end
                end
                RXACK, TXWR: begin
                    state_reg <= POLL;
                    u_we      <= 1'b0;
                    u_addr    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bridge.sv
// Scoreboard bench for uart_bridge with a cycle-level behavioural model of the
// uart bus port (registered dbr, tx busy timer, rx byte-ready flag).
module tb_uart_bridge;

    localparam int DEPTH   = 16;
    localparam int TX_TIME = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cpu_addr = 2'd0;
    logic       cpu_we = 1'b0;
    logic       cpu_re = 1'b0;
    logic [7:0] cpu_dbw = 8'h00;
    logic [7:0] cpu_dbr;
    logic       irq;
    logic       u_addr;
    logic       u_we;
    logic [7:0] u_dbw;
    logic [7:0] u_dbr;

    int checks = 0;
    int failures = 0;

    logic [7:0] rd_exp_q[$];
    logic [1:0] rd_addr_q[$];
    logic [7:0] tx_exp_q[$];
    logic [7:0] inj_q[$];

    logic       re_d = 1'b0;
    logic       tx_busy;
    int         busy_cnt;
    logic       rx_ok;
    logic [7:0] rx_buf;

    uart_bridge #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_addr (cpu_addr),
        .cpu_we   (cpu_we),
        .cpu_re   (cpu_re),
        .cpu_dbw  (cpu_dbw),
        .cpu_dbr  (cpu_dbr),
        .irq      (irq),
        .u_addr   (u_addr),
        .u_we     (u_we),
        .u_dbw    (u_dbw),
        .u_dbr    (u_dbr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // uart port model
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            u_dbr    <= 8'h00;
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
            rx_ok    <= 1'b0;
            rx_buf   <= 8'h00;
            inj_q.delete();
        end else begin
            u_dbr <= u_addr ? {tx_busy, rx_ok, 6'b0} : rx_buf;
            if (u_we && !u_addr) begin
                tx_busy  <= 1'b1;
                busy_cnt <= TX_TIME;
            end else if (busy_cnt > 1) begin
                busy_cnt <= busy_cnt - 1;
            end else if (busy_cnt == 1) begin
                busy_cnt <= 0;
                tx_busy  <= 1'b0;
            end
            if (u_we && u_addr) begin
                rx_ok <= 1'b0;
            end else if (!rx_ok && inj_q.size() > 0) begin
                rx_buf <= inj_q[0];
                rx_ok  <= 1'b1;
                inj_q.delete(0);
            end
        end
    end

    always @(posedge clk) re_d <= cpu_re & ~cpu_we;

    // Monitor: CPU read data and uart writes checked against the scoreboard queues.
    always @(negedge clk) begin
        if (re_d) begin
            if (rd_exp_q.size() == 0) begin
                check("rd_unexpected", 32'(cpu_dbr), 32'h100);
            end else begin
                check($sformatf("rd_addr%0d", rd_addr_q.pop_front()), 32'(cpu_dbr), 32'(rd_exp_q.pop_front()));
            end
        end
        if (!rst && u_we && !u_addr) begin
            if (tx_exp_q.size() == 0) begin
                check("tx_unexpected", 32'(u_dbw), 32'h100);
            end else begin
                check("tx_byte", 32'(u_dbw), 32'(tx_exp_q.pop_front()));
            end
        end
    end

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_addr = a; cpu_dbw = d; cpu_we = 1'b1;
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, input logic [7:0] exp);
        @(posedge clk); #1;
        cpu_addr = a; cpu_re = 1'b1;
        rd_exp_q.push_back(exp);
        rd_addr_q.push_back(a);
        @(posedge clk); #1;
        cpu_re = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!tx_busy && n < 50) begin @(negedge clk); n++; end
        check("tx_start", 32'(tx_busy), 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((tx_exp_q.size() > 0 || tx_busy) && n < 4000) begin @(negedge clk); n++; end
        check("tx_drain", 32'(tx_exp_q.size() == 0 && !tx_busy), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cpu_dbr", 32'(cpu_dbr), 32'h00);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_u_we", 32'(u_we), 32'h0);
        check("rst_u_addr", 32'(u_addr), 32'h0);
        check("rst_u_dbw", 32'(u_dbw), 32'h00);
        rst = 1'b0;
        wait_cycles(4);

        // Three bytes out in order, then idle status
        foreach (tx_exp_q[i]) ;
        for (int i = 0; i < 3; i++) begin
            tx_exp_q.push_back(8'h41 + 8'(i));
            cpu_write(REG_DATA_A(), 8'h41 + 8'(i));
        end
        wait_drain();
        cpu_read(2'd1, 8'h10);
        cpu_read(2'd2, 8'h00);
        cpu_read(2'd3, 8'h00);

        // Overfill TX while the uart is busy: 16 fit, the 17th is dropped
        tx_exp_q.push_back(8'h60);
        cpu_write(2'd0, 8'h60);
        wait_busy();
        for (int i = 0; i < 17; i++) begin
            if (i < DEPTH) tx_exp_q.push_back(8'h80 + 8'(i));
            cpu_write(2'd0, 8'h80 + 8'(i));
        end
        cpu_read(2'd1, 8'h88);
        cpu_write(2'd2, 8'h80);
        cpu_read(2'd1, 8'h80);
        wait_drain();
        cpu_read(2'd1, 8'h10);

        // Two received bytes, then a read of the empty RX FIFO
        inj_q.push_back(8'h5A);
        inj_q.push_back(8'hA5);
        wait_cycles(30);
        cpu_read(2'd1, 8'h50);
        cpu_read(2'd3, 8'h02);
        cpu_read(2'd0, 8'h5A);
        cpu_read(2'd0, 8'hA5);
        cpu_read(2'd0, 8'h00);
        cpu_read(2'd3, 8'h00);

        // DEPTH+1 received bytes with no reads: RX fills, overrun flagged
        for (int i = 0; i <= DEPTH; i++) inj_q.push_back(8'(i * 9 + 1));
        wait_cycles(200);
        cpu_read(2'd3, 8'(DEPTH));
        cpu_read(2'd1, 8'h70);
        for (int i = 0; i < DEPTH; i++) begin
            cpu_read(2'd0, 8'(i * 9 + 1));
            wait_cycles(4);
        end
        wait_cycles(20);
        cpu_read(2'd0, 8'(DEPTH * 9 + 1));
        cpu_read(2'd3, 8'h00);
        cpu_write(2'd2, 8'h80);
        cpu_read(2'd1, 8'h10);

        // RX interrupt rise and fall, then TX-empty interrupt
        cpu_write(2'd2, 8'h01);
        wait_cycles(2);
        @(negedge clk);
        check("irq_idle", 32'(irq), 32'h0);
        inj_q.push_back(8'h33);
        n = 0;
        while (!irq && n < 15) begin @(negedge clk); n++; end
        check("irq_rise", 32'(irq), 32'h1);
        cpu_read(2'd0, 8'h33);
        @(negedge clk);
        check("irq_hold", 32'(irq), 32'h1);
        @(negedge clk);
        check("irq_fall", 32'(irq), 32'h0);
        cpu_write(2'd2, 8'h02);
        @(negedge clk);
        check("irq_txie_lag", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_txie", 32'(irq), 32'h1);

        // Write+read together, then async reset mid-frame
        cpu_write(2'd2, 8'h01);
        inj_q.push_back(8'h77);
        wait_cycles(20);
        cpu_read(2'd2, 8'h01);
        @(negedge clk);
        check("irq_pre_rst", 32'(irq), 32'h1);
        tx_exp_q.push_back(8'h55);
        @(posedge clk); #1;
        cpu_addr = 2'd0; cpu_dbw = 8'h55; cpu_we = 1'b1; cpu_re = 1'b1;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_re = 1'b0;
        @(negedge clk);
        check("we_re_hold", 32'(cpu_dbr), 32'h01);
        for (int i = 0; i < 4; i++) cpu_write(2'd0, 8'hA1 + 8'(i));
        wait_busy();
        wait_cycles(5);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_cpu_dbr", 32'(cpu_dbr), 32'h00);
        check("arst_irq", 32'(irq), 32'h0);
        check("arst_u_we", 32'(u_we), 32'h0);
        check("arst_u_addr", 32'(u_addr), 32'h0);
        check("arst_u_dbw", 32'(u_dbw), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(300);
        cpu_read(2'd1, 8'h10);
        cpu_read(2'd2, 8'h00);
        cpu_read(2'd3, 8'h00);
        wait_cycles(3);

        check("rd_q_drained", 32'(rd_exp_q.size()), 32'd0);
        check("tx_q_drained", 32'(tx_exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [1:0] REG_DATA_A();
        return 2'd0;
    endfunction

endmodule
